// File: rtl/serial_mon_pkg.sv
// Shared definitions for the serial_rx link monitor: link-state encodings
// and a saturating increment used by the watchdog and statistics counters.
package serial_mon_pkg;

   localparam logic [1:0] LST_LOST   = 2'd0;
   localparam logic [1:0] LST_SEEK   = 2'd1;
   localparam logic [1:0] LST_LOCKED = 2'd2;

   // Returns val+1, or val unchanged once it has reached lim.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
      if (val >= lim) return val;
      return val + 32'd1;
   endfunction

endpackage

// File: rtl/serial_mon_fifo.sv
// First-word-fall-through FIFO for the link monitor. The head word is kept in
// its own register so the output holds its last value while the FIFO is empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module serial_mon_fifo #(
   parameter int DW = 64,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   output logic          full,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] head_data
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] head_q, head_d;
   logic          push_ok, pop_ok;

   assign full      = (cnt_q == (AW + 1)'(DEPTH));
   assign valid     = (cnt_q != '0);
   assign head_data = head_q;
   assign pop_ok    = pop & valid;
   assign push_ok   = push & (~full | pop_ok);

   // Next storage, pointers, occupancy and head word.
   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (push_ok) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + PTR_ONE;
      end
      if (pop_ok) rd_d = rd_q + PTR_ONE;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (pop_ok && (cnt_q > CNT_ONE))
         head_d = mem_q[rd_q + PTR_ONE];
      else if (push_ok && ((cnt_q == '0) || pop_ok))
         head_d = push_data;
   end

   // FIFO registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

endmodule

// File: rtl/serial_rx_monitor.sv
// Link monitor behind serial_rx: lock state machine with frame watchdog,
// FWFT buffering of good words, and link-health statistics.
// Statistics counters exist only when SERIAL_RX_MONITOR_STATS_EN is defined;
// otherwise good_cnt/err_cnt/ovf_cnt read 0 and clear_cnt is ignored.
//
// state  | meaning
// LOST   | no frame for TIMEOUT cycles, or out of reset
// SEEK   | frames seen, counting consecutive good frames toward lock
// LOCKED | link up, good words forwarded into the FIFO
module serial_rx_monitor #(
   parameter int DW       = 64,
   parameter int LOCK_N   = 3,
   parameter int UNLOCK_N = 2,
   parameter int TIMEOUT  = 400,
   parameter int FIFO_AW  = 2,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_sync,
   input  logic [DW-1:0] rx_d,
   input  logic          rx_err,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    link_state,
   output logic          link_up,
   input  logic          clear_cnt,
   output logic [CW-1:0] good_cnt,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] ovf_cnt
);

   import serial_mon_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [3:0]    LOCK_V   = 4'(LOCK_N);
   localparam logic [3:0]    UNLOCK_V = 4'(UNLOCK_N);
   localparam logic [TW-1:0] TMO_V    = TW'(TIMEOUT);

   logic [1:0]    state_q, state_d;
   logic [3:0]    streak_q, streak_d;
   logic [3:0]    errrun_q, errrun_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          link_up_q, link_up_d;
   logic          good, errf, timeout, lock_hit, push, fifo_full, drop;

   assign good    = rx_sync & ~rx_err;
   assign errf    = rx_sync & rx_err;
   assign timeout = (timer_q == TMO_V) & ~rx_sync;

   // Lock state machine and watchdog next-state; a frame always beats the timeout.
   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      errrun_d  = errrun_q;
      lock_hit  = 1'b0;
      timer_d   = rx_sync ? '0 : TW'(sat_inc(32'(timer_q), 32'(TIMEOUT)));
      if (timeout) begin
         state_d  = LST_LOST;
         streak_d = '0;
         errrun_d = '0;
      end else if (rx_sync) begin
         case (state_q)
            LST_LOST: begin
               state_d  = LST_SEEK;
               streak_d = good ? 4'd1 : 4'd0;
            end
            LST_SEEK: begin
               if (good) begin
                  streak_d = streak_q + 4'd1;
                  if (streak_q + 4'd1 == LOCK_V) begin
                     state_d  = LST_LOCKED;
                     errrun_d = '0;
                     lock_hit = 1'b1;
                  end
               end else begin
                  streak_d = '0;
               end
            end
            LST_LOCKED: begin
               if (good) begin
                  errrun_d = '0;
               end else begin
                  errrun_d = errrun_q + 4'd1;
                  if (errrun_q + 4'd1 == UNLOCK_V) begin
                     state_d  = LST_SEEK;
                     streak_d = '0;
                  end
               end
            end
            default: state_d = LST_LOST;
         endcase
      end
      link_up_d = (state_d == LST_LOCKED);
   end

   // State, watchdog and link_up registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LST_LOST;
         streak_q  <= '0;
         errrun_q  <= '0;
         timer_q   <= '0;
         link_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         errrun_q  <= errrun_d;
         timer_q   <= timer_d;
         link_up_q <= link_up_d;
      end
   end

   assign link_state = state_q;
   assign link_up    = link_up_q;

   // The frame that completes lock is forwarded along with every later good frame.
   assign push = good & ((state_q == LST_LOCKED) | lock_hit);
   assign drop = push & fifo_full & ~(out_valid & out_ready);

   serial_mon_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (rx_d),
      .full      (fifo_full),
      .pop       (out_ready),
      .valid     (out_valid),
      .head_data (out_data)
   );

`ifdef SERIAL_RX_MONITOR_STATS_EN
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

   logic [CW-1:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

   // Saturating statistics; clear overrides a same-cycle increment.
   always_comb begin
      good_cnt_d = good_cnt_q;
      err_cnt_d  = err_cnt_q;
      ovf_cnt_d  = ovf_cnt_q;
      if (clear_cnt) begin
         good_cnt_d = '0;
         err_cnt_d  = '0;
         ovf_cnt_d  = '0;
      end else begin
         if (good) good_cnt_d = CW'(sat_inc(32'(good_cnt_q), CNT_MAX));
         if (errf) err_cnt_d  = CW'(sat_inc(32'(err_cnt_q), CNT_MAX));
         if (drop) ovf_cnt_d  = CW'(sat_inc(32'(ovf_cnt_q), CNT_MAX));
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         good_cnt_q <= good_cnt_d;
         err_cnt_q  <= err_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign good_cnt = good_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign ovf_cnt  = ovf_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = clear_cnt | errf | drop;
   assign good_cnt     = '0;
   assign err_cnt      = '0;
   assign ovf_cnt      = '0;
`endif

endmodule

// File: tb/tb_serial_rx_monitor.sv
// Bench for serial_rx_monitor: directed scenarios with literal expectations
// plus a randomized run, all checked each cycle against a frame-level model.
module tb_serial_rx_monitor;

   localparam int DW       = 64;
   localparam int LOCK_N   = 3;
   localparam int UNLOCK_N = 2;
   localparam int TIMEOUT  = 400;
   localparam int CW       = 16;
   localparam int DEPTH    = 4;
   localparam int CMAX     = 65535;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_sync = 1'b0;
   logic [DW-1:0] rx_d = '0;
   logic          rx_err = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    link_state;
   logic          link_up;
   logic          clear_cnt = 1'b0;
   logic [CW-1:0] good_cnt, err_cnt, ovf_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_rx_monitor #(.DW(DW), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .TIMEOUT(TIMEOUT),
                       .FIFO_AW(2), .CW(CW)) dut (
      .clk(clk), .rst(rst), .rx_sync(rx_sync), .rx_d(rx_d), .rx_err(rx_err),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .link_state(link_state), .link_up(link_up), .clear_cnt(clear_cnt),
      .good_cnt(good_cnt), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] cexp(input int v);
`ifdef SERIAL_RX_MONITOR_STATS_EN
      return 64'(v);
`else
      return 64'(v * 0);
`endif
   endfunction

   // ---------------- behavioural model ----------------
   int            m_state = 0;   // 0 LOST, 1 SEEK, 2 LOCKED
   int            m_good_run = 0;
   int            m_bad_run = 0;
   int            m_idle = 0;    // cycles since the last frame, capped at TIMEOUT
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_last = '0;
   int            m_good = 0, m_err = 0, m_ovf = 0;

   task automatic model_reset();
      m_state = 0; m_good_run = 0; m_bad_run = 0; m_idle = 0;
      m_q.delete(); m_last = '0;
      m_good = 0; m_err = 0; m_ovf = 0;
   endtask

   task automatic model_step();
      bit good, bad, pop, push, dropped;
      good = rx_sync && !rx_err;
      bad  = rx_sync && rx_err;
      pop  = (m_q.size() > 0) && out_ready;
      push = good && (m_state == 2 || (m_state == 1 && m_good_run + 1 == LOCK_N));
      if (!rx_sync && m_idle == TIMEOUT) begin
         m_state = 0; m_good_run = 0; m_bad_run = 0;
      end else if (rx_sync) begin
         if (m_state == 0) begin
            m_state = 1; m_good_run = good ? 1 : 0;
         end else if (m_state == 1) begin
            if (good) begin
               m_good_run++;
               if (m_good_run == LOCK_N) begin m_state = 2; m_bad_run = 0; end
            end else m_good_run = 0;
         end else begin
            if (good) m_bad_run = 0;
            else begin
               m_bad_run++;
               if (m_bad_run == UNLOCK_N) begin m_state = 1; m_good_run = 0; end
            end
         end
      end
      m_idle = rx_sync ? 0 : ((m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT);
      if (pop) void'(m_q.pop_front());
      dropped = 1'b0;
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(rx_d);
         else dropped = 1'b1;
      end
      if (m_q.size() > 0) m_last = m_q[0];
      if (clear_cnt) begin
         m_good = 0; m_err = 0; m_ovf = 0;
      end else begin
         if (good && m_good < CMAX) m_good++;
         if (bad && m_err < CMAX) m_err++;
         if (dropped && m_ovf < CMAX) m_ovf++;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("link_state", 64'(link_state), 64'(m_state));
         check("link_up", 64'(link_up), 64'(m_state == 2));
         check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
         check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : m_last);
         check("good_cnt", 64'(good_cnt), cexp(m_good));
         check("err_cnt", 64'(err_cnt), cexp(m_err));
         check("ovf_cnt", 64'(ovf_cnt), cexp(m_ovf));
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   function automatic logic [63:0] mk(input int t, input int i);
      return {16'hF00D, 16'(t), 32'(i)};
   endfunction

   task automatic frame(input bit err, input logic [63:0] d);
      rx_sync = 1'b1; rx_err = err; rx_d = d;
      @(negedge clk);
      rx_sync = 1'b0; rx_err = 1'b0; rx_d = {$urandom, $urandom};
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic restart();
      rst = 1'b1; rx_sync = 1'b0; rx_err = 1'b0; clear_cnt = 1'b0;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_cnt = 1'b1;
      @(negedge clk);
      clear_cnt = 1'b0;
   endtask

   task automatic lock_up(input int t);
      for (int i = 1; i <= 3; i++) begin
         frame(1'b0, mk(t, 100 + i));
         idle(9);
      end
   endtask

   logic [63:0] dv[6];

   initial begin
      idle(3);
      rst = 1'b0;
      check("reset_state", 64'(link_state), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_data", out_data, 64'd0);

      // 1: five good frames, 168 cycles apart
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         frame(1'b0, mk(1, i));
         if (i < 3) begin
            check("t1_seek", 64'(link_state), 64'd1);
            check("t1_novalid", 64'(out_valid), 64'd0);
         end else begin
            check("t1_locked", 64'(link_state), 64'd2);
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_data", out_data, mk(1, i));
         end
         idle(167);
      end
      check("t1_good_cnt", 64'(good_cnt), cexp(5));
      check("t1_err_cnt", 64'(err_cnt), cexp(0));

      // 2: good, good, err, good x3
      restart();
      for (int i = 1; i <= 6; i++) begin
         frame(i == 3, mk(2, i));
         if (i < 6) begin
            check("t2_seek", 64'(link_state), 64'd1);
            check("t2_novalid", 64'(out_valid), 64'd0);
         end else begin
            check("t2_locked", 64'(link_state), 64'd2);
            check("t2_first_word", out_data, mk(2, 6));
         end
         idle(19);
      end
      check("t2_err_cnt", 64'(err_cnt), cexp(1));

      // 3: single err keeps lock, two consecutive drop it
      pulse_clear();
      frame(1'b1, mk(3, 1));
      check("t3_hold", 64'(link_state), 64'd2);
      check("t3_no_push", 64'(out_valid), 64'd0);
      idle(19);
      frame(1'b0, mk(3, 2));
      check("t3_push", out_data, mk(3, 2));
      idle(19);
      frame(1'b1, mk(3, 3));
      check("t3_still", 64'(link_state), 64'd2);
      idle(19);
      frame(1'b1, mk(3, 4));
      check("t3_seek", 64'(link_state), 64'd1);
      check("t3_err_cnt", 64'(err_cnt), cexp(3));

      // 4: watchdog
      restart();
      lock_up(4);
      idle(400 - 9);
      check("t4_before_to", 64'(link_state), 64'd2);
      idle(1);
      check("t4_lost", 64'(link_state), 64'd0);
      lock_up(4);
      idle(400 - 9);
      check("t4_at_limit", 64'(link_state), 64'd2);
      frame(1'b0, mk(4, 9));
      check("t4_saved", 64'(link_state), 64'd2);

      // 5: overflow, drain order, clear beats overflow
      restart();
      out_ready = 1'b1;
      lock_up(5);
      pulse_clear();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dv[i] = mk(5, i + 1);
         frame(1'b0, dv[i]);
         idle(2);
      end
      check("t5_ovf_cnt", 64'(ovf_cnt), cexp(2));
      for (int i = 0; i < 4; i++) begin
         check("t5_drain_valid", 64'(out_valid), 64'd1);
         check("t5_drain_data", out_data, dv[i]);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      check("t5_empty", 64'(out_valid), 64'd0);
      check("t5_hold_last", out_data, dv[3]);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) clear_cnt = 1'b1;
         frame(1'b0, mk(5, 20 + i));
         clear_cnt = 1'b0;
         idle(2);
      end
      check("t5_clear_ovf", 64'(ovf_cnt), 64'd0);
      out_ready = 1'b1;
      idle(6);

      // 6: asynchronous reset between edges
      restart();
      lock_up(6);
      #2 rst = 1'b1;
      #1;
      check("t6_state", 64'(link_state), 64'd0);
      check("t6_link_up", 64'(link_up), 64'd0);
      check("t6_valid", 64'(out_valid), 64'd0);
      check("t6_counts", 64'(good_cnt) | 64'(err_cnt) | 64'(ovf_cnt), 64'd0);
      idle(2);
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         frame(1'b0, mk(6, i));
         check("t6_relock", 64'(link_state), (i == 3) ? 64'd2 : 64'd1);
         idle(9);
      end

      // Randomized traffic, checked every cycle by the model
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 1500; c++) begin
            rx_sync   = ($urandom_range(0, 99) < 10 + ph * 15);
            rx_err    = ($urandom_range(0, 4) == 0);
            rx_d      = {$urandom, $urandom};
            out_ready = (ph == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clear_cnt = ($urandom_range(0, 199) == 0);
            @(negedge clk);
         end
         rx_sync = 1'b0; rx_err = 1'b0; clear_cnt = 1'b0;
         idle(410 + $urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
